// File: rtl/stopwatch_core.sv
// stopwatch_core: BCD stopwatch / countdown timer with lap freeze.
// Optional LAP feature: define STOPWATCH_CORE_LAP_EN.
//
// Ports:
//   clk, rst_n         clock, async active-low reset
//   start_stop         pulse: toggle run/pause
//   lap                pulse: toggle display freeze
//   clear              pulse: back to IDLE, count zero
//   load, load_value   pulse + BCD preset (digit 0 in [3:0])
//   up_down            1 = count up, 0 = count down
//   count, display     live BCD count / shown value
//   running            high in RUNNING or LAP
//   lap_active         high in LAP
//   expired            high in EXPIRED
//   wrap               pulse on up-count wrap all-9s -> 0
module stopwatch_core #(
    parameter int NUMBER_OF_DIGITS            = 4,
    parameter int BOARD_CLOCK_FREQUENCY_IN_HZ = 100_000_000,
    parameter int TICK_RATE_IN_HZ             = 100
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start_stop,
    input  logic                          lap,
    input  logic                          clear,
    input  logic                          load,
    input  logic [4*NUMBER_OF_DIGITS-1:0] load_value,
    input  logic                          up_down,
    output logic [4*NUMBER_OF_DIGITS-1:0] count,
    output logic [4*NUMBER_OF_DIGITS-1:0] display,
    output logic                          running,
    output logic                          lap_active,
    output logic                          expired,
    output logic                          wrap
);

    localparam int W   = 4 * NUMBER_OF_DIGITS;
    localparam int DIV = BOARD_CLOCK_FREQUENCY_IN_HZ / TICK_RATE_IN_HZ;
    localparam int PW  = $clog2(DIV);
    localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
    localparam logic [W-1:0]  ALL9 = {NUMBER_OF_DIGITS{4'h9}};

`ifdef STOPWATCH_CORE_LAP_EN
    typedef enum logic [2:0] {
        S_IDLE, S_RUN, S_PAUSE, S_EXP, S_LAP
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE, S_RUN, S_PAUSE, S_EXP
    } state_t;
`endif

    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < NUMBER_OF_DIGITS; i++) begin
            if (c) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         b;
        r = v;
        b = 1'b1;
        for (int i = 0; i < NUMBER_OF_DIGITS; i++) begin
            if (b) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Nibbles A-F clamp to 9 so the count is always valid BCD.
    function automatic logic [W-1:0] bcd_fix(input logic [W-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < NUMBER_OF_DIGITS; i++) begin
            r[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd9 : v[4*i +: 4];
        end
        return r;
    endfunction

    state_t         st, st_n;
    logic [PW-1:0]  pre, pre_n;
    logic [W-1:0]   cnt_n;
    logic           wrap_n;
    logic           active;
    logic           tick;

    always_comb begin
        active = (st == S_RUN);
`ifdef STOPWATCH_CORE_LAP_EN
        active = active | (st == S_LAP);
`endif
        tick   = active && (pre == PMAX);
        st_n   = st;
        pre_n  = pre;
        cnt_n  = count;
        wrap_n = 1'b0;

        if (active) begin
            pre_n = tick ? '0 : pre + 1'b1;
        end

        if (tick) begin
            if (up_down) begin
                if (count == ALL9) begin
                    cnt_n  = '0;
                    wrap_n = 1'b1;
                end else begin
                    cnt_n = bcd_inc(count);
                end
            end else begin
                // Stop at zero rather than borrowing into all-9s.
                if (count == '0 || bcd_dec(count) == '0) begin
                    cnt_n = '0;
                    st_n  = S_EXP;
                end else begin
                    cnt_n = bcd_dec(count);
                end
            end
        end

        if (clear) begin
            st_n   = S_IDLE;
            cnt_n  = '0;
            pre_n  = '0;
            wrap_n = 1'b0;
        end else if (load) begin
            cnt_n  = bcd_fix(load_value);
            pre_n  = '0;
            wrap_n = 1'b0;
            st_n   = (st == S_EXP) ? S_PAUSE : st;
        end else if (start_stop && st_n == st) begin
            unique case (st)
                S_IDLE: begin
                    st_n  = S_RUN;
                    pre_n = '0;
                end
                S_RUN:   st_n = S_PAUSE;
                S_PAUSE: st_n = S_RUN;
`ifdef STOPWATCH_CORE_LAP_EN
                S_LAP:   st_n = S_PAUSE;
`endif
                default: ;
            endcase
`ifdef STOPWATCH_CORE_LAP_EN
        end else if (lap && st_n == st) begin
            if (st == S_RUN) begin
                st_n = S_LAP;
            end else if (st == S_LAP) begin
                st_n = S_RUN;
            end
`endif
        end
    end

`ifdef STOPWATCH_CORE_LAP_EN
    logic [W-1:0] disp_n;

    // Latch the pre-update count on LAP entry, hold while in LAP.
    always_comb begin
        if (st_n == S_LAP) begin
            disp_n = (st == S_LAP) ? display : count;
        end else begin
            disp_n = cnt_n;
        end
    end
`else
    logic unused_lap;
    assign unused_lap = lap;
    assign display    = count;
    assign lap_active = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st      <= S_IDLE;
            pre     <= '0;
            count   <= '0;
            running <= 1'b0;
            expired <= 1'b0;
            wrap    <= 1'b0;
`ifdef STOPWATCH_CORE_LAP_EN
            display    <= '0;
            lap_active <= 1'b0;
`endif
        end else begin
            st      <= st_n;
            pre     <= pre_n;
            count   <= cnt_n;
            running <= (st_n == S_RUN)
`ifdef STOPWATCH_CORE_LAP_EN
                       || (st_n == S_LAP)
`endif
                       ;
            expired <= (st_n == S_EXP);
            wrap    <= wrap_n;
`ifdef STOPWATCH_CORE_LAP_EN
            display    <= disp_n;
            lap_active <= (st_n == S_LAP);
`endif
        end
    end

endmodule

// File: tb/tb_stopwatch_core.sv
// tb_stopwatch_core: directed vector bench for stopwatch_core.
// DIV = 10, four digits; works with or without STOPWATCH_CORE_LAP_EN.
module tb_stopwatch_core;

    localparam int W = 16;

    localparam logic [3:0] P_NO  = 4'b0000;
    localparam logic [3:0] P_CLR = 4'b1000;
    localparam logic [3:0] P_LD  = 4'b0100;
    localparam logic [3:0] P_SS  = 4'b0010;
    localparam logic [3:0] P_LAP = 4'b0001;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start_stop = 1'b0;
    logic         lap = 1'b0;
    logic         clear = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_value = '0;
    logic         up_down = 1'b1;
    logic [W-1:0] count;
    logic [W-1:0] display;
    logic         running;
    logic         lap_active;
    logic         expired;
    logic         wrap;

    stopwatch_core #(
        .NUMBER_OF_DIGITS           (4),
        .BOARD_CLOCK_FREQUENCY_IN_HZ(1000),
        .TICK_RATE_IN_HZ            (100)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_stop(start_stop),
        .lap       (lap),
        .clear     (clear),
        .load      (load),
        .load_value(load_value),
        .up_down   (up_down),
        .count     (count),
        .display   (display),
        .running   (running),
        .lap_active(lap_active),
        .expired   (expired),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   p;
        logic [W-1:0] lv;
        logic         ud;
        int           w;
        logic [W-1:0] cnt;
        logic [W-1:0] disp;
        logic         run;
        logic         lapa;
        logic         ex;
        logic         wr;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mk(
        input logic [3:0] p, input logic [W-1:0] lv,
        input logic ud, input int w,
        input logic [W-1:0] cnt, input logic [W-1:0] disp,
        input logic run, input logic lapa,
        input logic ex, input logic wr);
        vec_t v;
        v.p = p;     v.lv = lv;     v.ud = ud;   v.w = w;
        v.cnt = cnt; v.disp = disp; v.run = run; v.lapa = lapa;
        v.ex = ex;   v.wr = wr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input vec_t v);
        logic [W-1:0] ed;
        logic         el;
`ifdef STOPWATCH_CORE_LAP_EN
        ed = v.disp;
        el = v.lapa;
`else
        ed = v.cnt;
        el = 1'b0;
`endif
        chk({tag, ".count"},      count,            v.cnt);
        chk({tag, ".display"},    display,          ed);
        chk({tag, ".running"},    W'(running),      W'(v.run));
        chk({tag, ".lap_active"}, W'(lap_active),   W'(el));
        chk({tag, ".expired"},    W'(expired),      W'(v.ex));
        chk({tag, ".wrap"},       W'(wrap),         W'(v.wr));
    endtask

    // One pulse cycle, then v.w idle cycles, then check at negedge.
    task automatic apply(input string tag, input vec_t v);
        clear      = v.p[3];
        load       = v.p[2];
        start_stop = v.p[1];
        lap        = v.p[0];
        load_value = v.lv;
        up_down    = v.ud;
        @(negedge clk);
        clear      = 1'b0;
        load       = 1'b0;
        start_stop = 1'b0;
        lap        = 1'b0;
        repeat (v.w) @(negedge clk);
        check_all(tag, v);
    endtask

    initial begin
        // reset state
        vecs.push_back(mk(P_NO, 16'h0, 1, 0, 16'h0000, 16'h0000, 0, 0, 0, 0));
        // first tick exactly 10 cycles after start, 0x0010 at 100
        vecs.push_back(mk(P_SS, 16'h0, 1, 9, 16'h0000, 16'h0000, 1, 0, 0, 0));
        vecs.push_back(mk(P_NO, 16'h0, 1, 0, 16'h0001, 16'h0001, 1, 0, 0, 0));
        vecs.push_back(mk(P_NO, 16'h0, 1, 89, 16'h0010, 16'h0010, 1, 0, 0, 0));
        // clear beats start_stop
        vecs.push_back(mk(P_CLR | P_SS, 16'h0, 1, 0, 16'h0000, 16'h0000, 0, 0, 0, 0));
        vecs.push_back(mk(P_NO, 16'h0, 1, 14, 16'h0000, 16'h0000, 0, 0, 0, 0));
        // up wrap
        vecs.push_back(mk(P_LD, 16'h9998, 1, 0, 16'h9998, 16'h9998, 0, 0, 0, 0));
        vecs.push_back(mk(P_SS, 16'h0, 1, 9, 16'h9998, 16'h9998, 1, 0, 0, 0));
        vecs.push_back(mk(P_NO, 16'h0, 1, 0, 16'h9999, 16'h9999, 1, 0, 0, 0));
        vecs.push_back(mk(P_NO, 16'h0, 1, 8, 16'h9999, 16'h9999, 1, 0, 0, 0));
        vecs.push_back(mk(P_NO, 16'h0, 1, 0, 16'h0000, 16'h0000, 1, 0, 0, 1));
        vecs.push_back(mk(P_NO, 16'h0, 1, 0, 16'h0000, 16'h0000, 1, 0, 0, 0));
        vecs.push_back(mk(P_CLR, 16'h0, 1, 0, 16'h0000, 16'h0000, 0, 0, 0, 0));
        // countdown to expiry
        vecs.push_back(mk(P_LD, 16'h0002, 0, 0, 16'h0002, 16'h0002, 0, 0, 0, 0));
        vecs.push_back(mk(P_SS, 16'h0, 0, 10, 16'h0001, 16'h0001, 1, 0, 0, 0));
        vecs.push_back(mk(P_NO, 16'h0, 0, 9, 16'h0000, 16'h0000, 0, 0, 1, 0));
        vecs.push_back(mk(P_SS, 16'h0, 0, 9, 16'h0000, 16'h0000, 0, 0, 1, 0));
        vecs.push_back(mk(P_LAP, 16'h0, 0, 0, 16'h0000, 16'h0000, 0, 0, 1, 0));
        // load from EXPIRED -> PAUSED, A clamps to 9
        vecs.push_back(mk(P_LD, 16'h00A5, 0, 0, 16'h0095, 16'h0095, 0, 0, 0, 0));
        vecs.push_back(mk(P_NO, 16'h0, 0, 19, 16'h0095, 16'h0095, 0, 0, 0, 0));
        vecs.push_back(mk(P_SS, 16'h0, 1, 10, 16'h0096, 16'h0096, 1, 0, 0, 0));
        vecs.push_back(mk(P_CLR, 16'h0, 1, 0, 16'h0000, 16'h0000, 0, 0, 0, 0));
        // lap freeze
        vecs.push_back(mk(P_LD, 16'h0005, 1, 0, 16'h0005, 16'h0005, 0, 0, 0, 0));
        vecs.push_back(mk(P_SS, 16'h0, 1, 2, 16'h0005, 16'h0005, 1, 0, 0, 0));
        vecs.push_back(mk(P_LAP, 16'h0, 1, 0, 16'h0005, 16'h0005, 1, 1, 0, 0));
        vecs.push_back(mk(P_NO, 16'h0, 1, 26, 16'h0008, 16'h0005, 1, 1, 0, 0));
        vecs.push_back(mk(P_LAP, 16'h0, 1, 0, 16'h0008, 16'h0008, 1, 0, 0, 0));
        vecs.push_back(mk(P_LAP, 16'h0, 1, 0, 16'h0008, 16'h0008, 1, 1, 0, 0));
        vecs.push_back(mk(P_SS, 16'h0, 1, 0, 16'h0008, 16'h0008, 0, 0, 0, 0));
        vecs.push_back(mk(P_CLR, 16'h0, 1, 0, 16'h0000, 16'h0000, 0, 0, 0, 0));

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply($sformatf("v%0d", i), vecs[i]);
        end

        // async reset mid-count
        apply("r0", mk(P_LD, 16'h0123, 1, 0, 16'h0123, 16'h0123, 0, 0, 0, 0));
        apply("r1", mk(P_SS, 16'h0, 1, 4, 16'h0123, 16'h0123, 1, 0, 0, 0));
        #2;
        rst_n = 1'b0;
        #1;
        check_all("r2", mk(P_NO, 16'h0, 1, 0, 16'h0000, 16'h0000, 0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check_all("r3", mk(P_NO, 16'h0, 1, 0, 16'h0000, 16'h0000, 0, 0, 0, 0));
        apply("r4", mk(P_SS, 16'h0, 1, 9, 16'h0000, 16'h0000, 1, 0, 0, 0));
        apply("r5", mk(P_NO, 16'h0, 1, 0, 16'h0001, 16'h0001, 1, 0, 0, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stopwatch_core.md
STOPWATCH_CORE -- requirements
Module: stopwatch_core

Interface
REQ-001 Parameter NUMBER_OF_DIGITS, default 4: BCD digits in the count, 1..8.
REQ-002 Parameter BOARD_CLOCK_FREQUENCY_IN_HZ, default 100_000_000: clk frequency.
REQ-003 Parameter TICK_RATE_IN_HZ, default 100: count rate; DIV = BOARD_CLOCK_FREQUENCY_IN_HZ / TICK_RATE_IN_HZ, integer and >= 2.
REQ-004 Ports, listed as name, direction, width, meaning:
- clk  in  1  sole clock; all state rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start_stop  in  1  one-cycle pulse that toggles run/pause.
- lap  in  1  one-cycle pulse that toggles display freeze.
- clear  in  1  one-cycle pulse that returns to IDLE and zero.
- load  in  1  one-cycle pulse that copies load_value into count.
- load_value  in  4*NUMBER_OF_DIGITS  BCD preset; digit 0 in [3:0].
- up_down  in  1  1 = count up, 0 = count down; sampled per tick.
- count  out  4*NUMBER_OF_DIGITS  live BCD count.
- display  out  4*NUMBER_OF_DIGITS  count, or the frozen lap value.
- running  out  1  high in RUNNING or LAP.
- lap_active  out  1  high in LAP.
- expired  out  1  high in EXPIRED.
- wrap  out  1  one-cycle pulse on an up-count wrap from all-9s to 0.

Function
REQ-005 States are IDLE, RUNNING, PAUSED, LAP and EXPIRED; outputs are registered.
REQ-006 Transitions:
- IDLE --start_stop--> RUNNING.
- RUNNING --start_stop--> PAUSED; PAUSED --start_stop--> RUNNING.
- RUNNING --lap--> LAP; LAP --lap--> RUNNING.
- LAP --start_stop--> PAUSED, with lap_active dropping.
- Any state --clear--> IDLE.
- EXPIRED ignores start_stop and lap.
REQ-007 Simultaneous pulses follow the priority clear > load > start_stop > lap; only the highest-priority pulse takes effect in that cycle.
REQ-008 Prescaler:
- Counts 0..DIV-1 only while in RUNNING or LAP, and holds its value in PAUSED.
- Is zeroed by clear, by load and on the IDLE->RUNNING transition.
- An internal tick fires in the cycle the prescaler equals DIV-1.
REQ-009 On a tick, count updates in the next cycle. First tick occurs DIV cycles after the start_stop pulse from IDLE.
REQ-010 Up-count: BCD increment with ripple carry across digits; from all-9s the count becomes all-0s and wrap pulses for one cycle coincident with the update.
REQ-011 Down-count: BCD decrement with borrow. When the count reaches 0, the next state is EXPIRED in the same update, with count 0 and running low.
REQ-012 A down tick at count 0 leaves the count at 0 and enters EXPIRED; it never wraps to all-9s.
REQ-013 load in any state:
- Count := load_value, prescaler := 0, state unchanged.
- From EXPIRED, a load goes to PAUSED.
- Non-BCD nibbles (A-F) are loaded as 9.
REQ-014 display equals count in every state except LAP. On entry to LAP, display latches count and holds it while count keeps advancing; on LAP exit, display tracks count again next cycle.
REQ-015 Status outputs decode the next state, so they are valid in the same cycle as the state register.

Reset
REQ-016 When rst_n is low, asynchronously:
- State := IDLE, prescaler := 0.
- count, display := 0; running, lap_active, expired, wrap := 0.
REQ-017 Reset asserted mid-tick or mid-LAP discards all pending updates. The first activity after release requires a new start_stop pulse.

Configuration
REQ-018 Macro STOPWATCH_CORE_LAP_EN.
- When defined: the LAP state, the lap input behaviour and the display latch are present.
- When undefined: the lap input is ignored, lap_active is tied 0, display is wired to count, and the LAP state and latch registers are not synthesised.

Verification
REQ-019 The bench SHALL cover the following, with DIV = 10 (BOARD_CLOCK_FREQUENCY_IN_HZ = 1000, TICK_RATE_IN_HZ = 100) and NUMBER_OF_DIGITS = 4:
- Reset, then start_stop, up_down = 1 -> count = 0x0001 exactly 10 cycles after the pulse, and 0x0010 at 100 cycles.
- load 0x9998, then start_stop, up_down = 1 -> count goes 0x9999, then 0x0000; wrap is high for 1 cycle only.
- load 0x0002, up_down = 0, start_stop -> count goes 0x0001, then 0x0000; expired = 1 and running = 0; a further start_stop leaves the state unchanged.
- Running at 0x0005, lap -> display holds 0x0005 while count reaches 0x0008; lap again -> display = 0x0008 next cycle. With the macro undefined, display always equals count.
- clear and start_stop in the same cycle while RUNNING -> IDLE, count = 0x0000, running = 0.
- rst_n pulsed low asynchronously mid-count at 0x0123 -> all outputs 0 immediately; no tick follows release until a new start_stop.
